// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared constants and types for the seven-segment digit receiver.
//             Segment codes use the bus order {g,f,e,d,c,b,a}, active-high.
//  Contents : c_digit_w      - width of a decoded digit
//             c_seg_0..9     - segment codes of the ten decimal digits
//             c_seg_blank    - all segments off
//             rx_state_t     - receiver lock state
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int c_digit_w = 4;

    localparam logic [6:0] c_seg_blank = 7'h00;
    localparam logic [6:0] c_seg_0     = 7'h3F;
    localparam logic [6:0] c_seg_1     = 7'h06;
    localparam logic [6:0] c_seg_2     = 7'h5B;
    localparam logic [6:0] c_seg_3     = 7'h4F;
    localparam logic [6:0] c_seg_4     = 7'h66;
    localparam logic [6:0] c_seg_5     = 7'h6D;
    localparam logic [6:0] c_seg_6     = 7'h7D;
    localparam logic [6:0] c_seg_7     = 7'h07;
    localparam logic [6:0] c_seg_8     = 7'h7F;
    localparam logic [6:0] c_seg_9     = 7'h6F;

    // UNLOCKED: no reference digit for the sequence check yet.
    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational seven-segment pattern decoder.
//  Ports    : pattern (in, 7)  - segment bus {g,f,e,d,c,b,a}
//             digit   (out, 4) - decoded value 0..9 (0 when not a digit)
//             valid   (out, 1) - pattern is one of the ten digit codes
//             blank   (out, 1) - pattern is all segments off
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0]           pattern,
    output logic [c_digit_w-1:0] digit,
    output logic                 valid,
    output logic                 blank
);

    always_comb begin
        digit = '0;
        valid = 1'b1;
        blank = 1'b0;
        case (pattern)
            c_seg_0:     digit = 4'd0;
            c_seg_1:     digit = 4'd1;
            c_seg_2:     digit = 4'd2;
            c_seg_3:     digit = 4'd3;
            c_seg_4:     digit = 4'd4;
            c_seg_5:     digit = 4'd5;
            c_seg_6:     digit = 4'd6;
            c_seg_7:     digit = 4'd7;
            c_seg_8:     digit = 4'd8;
            c_seg_9:     digit = 4'd9;
            c_seg_blank: begin
                valid = 1'b0;
                blank = 1'b1;
            end
            default:     valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_digit_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_digit_receiver
//  Purpose  : Receives an asynchronous seven-segment bus, filters glitches,
//             decodes digits, checks that digits count up modulo 10 and
//             measures the interval between successive digits.
//  Ports    : clk, reset (sync, active-high)
//             seg_in       (in, 7)         - {g,f,e,d,c,b,a}, asynchronous
//             digit        (out, 4)        - last accepted digit
//             digit_valid  (out, 1)        - pulse on digit update
//             pattern_err  (out, 1)        - pulse on accepted invalid code
//             seq_err      (out, 1)        - pulse on out-of-sequence digit
//             err_count    (out, 8)        - saturating error count
//             period       (out, PERIOD_W) - cycles between last two digits
//             period_valid (out, 1)        - pulse on period update
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_digit_receiver
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           seg_in,
    output logic [c_digit_w-1:0] digit,
    output logic                 digit_valid,
    output logic                 pattern_err,
    output logic                 seq_err,
    output logic [7:0]           err_count,
    output logic [PERIOD_W-1:0]  period,
    output logic                 period_valid
);

    localparam logic [3:0]          c_stable_last = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0]          c_stable_max  = 4'(STABLE_CYCLES);
    localparam logic [PERIOD_W-1:0] c_period_max  = {PERIOD_W{1'b1}};

    // ------------------------------------------------------------------
    // Synchronizer and stability filter
    // ------------------------------------------------------------------
    logic [6:0] r_sync1, r_sync2, r_cand, r_last;
    logic [3:0] r_stab;
    logic       w_same, w_accept;

    assign w_same = (r_sync2 == r_cand);
    // The sample that completes the stable window is the accepting one;
    // the counter then parks at STABLE_CYCLES so it cannot fire again.
    assign w_accept = w_same && (r_stab == c_stable_last) && (r_sync2 != r_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_last  <= '0;
            r_stab  <= '0;
        end else begin
            r_sync1 <= seg_in;
            r_sync2 <= r_sync1;
            if (!w_same) begin
                r_cand <= r_sync2;
                r_stab <= 4'd1;
            end else if (r_stab != c_stable_max) begin
                r_stab <= r_stab + 4'd1;
            end
            if (w_accept) begin
                r_last <= r_sync2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [c_digit_w-1:0] w_dec_digit;
    logic                 w_dec_valid, w_dec_blank;

    seg7_decode u_decode (
        .pattern (r_sync2),
        .digit   (w_dec_digit),
        .valid   (w_dec_valid),
        .blank   (w_dec_blank)
    );

    // ------------------------------------------------------------------
    // Lock FSM, sequence check, period and error counters
    // ------------------------------------------------------------------
    rx_state_t            r_state;
    logic [c_digit_w-1:0] r_digit;
    logic                 r_digit_valid, r_pattern_err, r_seq_err, r_period_valid;
    logic [7:0]           r_err_count;
    logic [PERIOD_W-1:0]  r_period, r_pcnt;

    logic [c_digit_w-1:0] w_next_digit;
    logic [PERIOD_W-1:0]  w_pcnt_inc;
    logic                 w_digit_acc, w_invalid_acc, w_blank_acc, w_seq_fail;

    assign w_next_digit  = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
    assign w_pcnt_inc    = (r_pcnt == c_period_max) ? r_pcnt : r_pcnt + 1'b1;
    assign w_digit_acc   = w_accept && w_dec_valid;
    assign w_blank_acc   = w_accept && w_dec_blank;
    assign w_invalid_acc = w_accept && !w_dec_valid && !w_dec_blank;
    assign w_seq_fail    = w_digit_acc && (r_state == ST_LOCKED)
                           && (w_dec_digit != w_next_digit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_UNLOCKED;
            r_digit        <= '0;
            r_digit_valid  <= 1'b0;
            r_pattern_err  <= 1'b0;
            r_seq_err      <= 1'b0;
            r_period_valid <= 1'b0;
            r_err_count    <= '0;
            r_period       <= '0;
            r_pcnt         <= '0;
        end else begin
            r_digit_valid  <= 1'b0;
            r_pattern_err  <= 1'b0;
            r_seq_err      <= 1'b0;
            r_period_valid <= 1'b0;

            if (r_state == ST_LOCKED) begin
                r_pcnt <= w_pcnt_inc;
            end

            if ((w_seq_fail || w_invalid_acc) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end

            case (r_state)
                ST_UNLOCKED: begin
                    if (w_digit_acc) begin
                        r_digit       <= w_dec_digit;
                        r_digit_valid <= 1'b1;
                        r_pcnt        <= '0;
                        r_state       <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_digit_acc) begin
                        r_digit        <= w_dec_digit;
                        r_digit_valid  <= 1'b1;
                        r_seq_err      <= w_seq_fail;
                        // Counter was cleared at the previous digit, so the
                        // elapsed edge count is one more than its value.
                        r_period       <= w_pcnt_inc;
                        r_period_valid <= 1'b1;
                        r_pcnt         <= '0;
                    end else if (w_blank_acc) begin
                        r_state <= ST_UNLOCKED;
                    end
                end
                default: r_state <= ST_UNLOCKED;
            endcase

            if (w_invalid_acc) begin
                r_pattern_err <= 1'b1;
            end
        end
    end

    assign digit        = r_digit;
    assign digit_valid  = r_digit_valid;
    assign pattern_err  = r_pattern_err;
    assign seq_err      = r_seq_err;
    assign err_count    = r_err_count;
    assign period       = r_period;
    assign period_valid = r_period_valid;

endmodule
`default_nettype wire

// File: tb/tb_seg7_digit_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_digit_receiver
//  Purpose  : Self-checking bench for seg7_digit_receiver. A cycle model built
//             from the acceptance rules predicts every output each cycle;
//             directed scenarios add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_digit_receiver;

    localparam int  S        = 4;
    localparam int  PW       = 24;
    localparam longint c_pmax = (64'd1 << PW) - 1;

    logic          clk;
    logic          reset;
    logic [6:0]    seg_in;
    logic [3:0]    digit;
    logic          digit_valid, pattern_err, seq_err, period_valid;
    logic [7:0]    err_count;
    logic [PW-1:0] period;

    seg7_digit_receiver #(
        .STABLE_CYCLES (S),
        .PERIOD_W      (PW)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .pattern_err  (pattern_err),
        .seq_err      (seq_err),
        .err_count    (err_count),
        .period       (period),
        .period_valid (period_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: digit table, stable-run rule, mod-10 sequence,
    // period as edge-number difference between consecutive locked digits.
    // ------------------------------------------------------------------
    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (codes[i] == p) return i;
        return -1;
    endfunction

    bit         started = 0;
    longint     edge_no = 0;
    longint     t_last  = 0;
    logic [6:0] s1, s2, run_val, last_acc;
    int         run_len;
    bit         locked;
    int         e_digit, e_err;
    longint     e_period;
    bit         e_dv, e_pe, e_se, e_pv;

    always @(posedge clk) begin
        logic [6:0] smp;
        int idx;
        edge_no++;
        e_dv = 0; e_pe = 0; e_se = 0; e_pv = 0;
        if (reset) begin
            started = 1;
            s1 = 0; s2 = 0; run_val = 0; run_len = 0; last_acc = 0;
            locked = 0; e_digit = 0; e_err = 0; e_period = 0;
        end else if (started) begin
            smp = s2; s2 = s1; s1 = seg_in;
            if (smp == run_val) run_len++;
            else begin
                run_val = smp;
                run_len = 1;
            end
            if (run_len == S && smp != last_acc) begin
                last_acc = smp;
                idx = lookup(smp);
                if (idx >= 0) begin
                    if (locked) begin
                        e_pv = 1;
                        e_period = (edge_no - t_last > c_pmax) ? c_pmax : edge_no - t_last;
                        if (idx != (e_digit + 1) % 10) begin
                            e_se = 1;
                            if (e_err < 255) e_err++;
                        end
                    end
                    e_digit = idx;
                    e_dv    = 1;
                    locked  = 1;
                    t_last  = edge_no;
                end else if (smp == 7'h00) begin
                    locked = 0;
                end else begin
                    e_pe = 1;
                    if (e_err < 255) e_err++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("digit",        digit,        e_digit);
            check("digit_valid",  digit_valid,  e_dv);
            check("pattern_err",  pattern_err,  e_pe);
            check("seq_err",      seq_err,      e_se);
            check("err_count",    err_count,    e_err);
            check("period",       period,       e_period);
            check("period_valid", period_valid, e_pv);
        end
    end

    // Pulse tallies for the directed scenarios.
    int n_dv = 0, n_pe = 0, n_se = 0, n_pv = 0;
    always @(posedge clk) begin
        #1;
        if (digit_valid)  n_dv++;
        if (pattern_err)  n_pe++;
        if (seq_err)      n_se++;
        if (period_valid) n_pv++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at a negedge)
    // ------------------------------------------------------------------
    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) @(negedge clk);
    endtask

    // Edges from the current negedge until digit_valid is seen (bounded).
    task automatic wait_dv(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!digit_valid && n < 40);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        int dv0, pe0, se0, pv0;
        logic [6:0] seq [11] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h3F};
        reset  = 1'b1;
        seg_in = 7'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_digit",  digit,       0);
        check("reset_errcnt", err_count,   0);
        check("reset_period", period,      0);
        check("reset_dv",     digit_valid, 0);
        repeat (10) @(negedge clk);

        // Full count 0..9,0 at 1000 cycles per digit
        dv0 = n_dv; se0 = n_se; pv0 = n_pv;
        seg_in = seq[0];
        wait_dv(lat);
        check("latency_first", lat, S + 2);
        repeat (1000 - lat) @(negedge clk);
        for (int i = 1; i < 11; i++) hold(seq[i], 1000);
        check("count_dv_pulses", n_dv - dv0, 11);
        check("count_seq_errs",  n_se - se0, 0);
        check("count_pv_pulses", n_pv - pv0, 10);
        check("count_last_dig",  digit, 0);
        check("count_period",    period, 1000);

        // Short glitch to 4 while showing 3
        hold(7'h06, 20); hold(7'h5B, 20); hold(7'h4F, 20);
        check("glitch_pre_digit", digit, 3);
        dv0 = n_dv; pe0 = n_pe;
        hold(7'h66, 3);
        hold(7'h4F, 20);
        check("glitch_no_dv", n_dv - dv0, 0);
        check("glitch_no_pe", n_pe - pe0, 0);
        check("glitch_digit", digit, 3);

        // Out-of-sequence digit, then an invalid pattern
        do_reset();
        hold(7'h00, 5);
        se0 = n_se; pe0 = n_pe;
        hold(7'h5B, 20);
        check("seq_first_digit", digit, 2);
        hold(7'h7D, 20);
        check("seq_digit",  digit, 6);
        check("seq_pulse",  n_se - se0, 1);
        check("seq_errcnt", err_count, 1);
        hold(7'h49, 20);
        check("pat_pulse",  n_pe - pe0, 1);
        check("pat_digit",  digit, 6);
        check("pat_errcnt", err_count, 2);

        // Blank unlocks: next digit has no sequence or period check
        hold(7'h6D, 20);
        check("blank_pre_digit", digit, 5);
        se0 = n_se; pv0 = n_pv; pe0 = n_pe;
        hold(7'h00, 20);
        hold(7'h06, 20);
        check("blank_no_seq", n_se - se0, 0);
        check("blank_no_pv",  n_pv - pv0, 0);
        check("blank_no_pe",  n_pe - pe0, 0);
        check("blank_digit",  digit, 1);

        // Error counter saturation
        pe0 = n_pe;
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h01 : 7'h02, 10);
        check("sat_pe_pulses", n_pe - pe0, 300);
        check("sat_errcnt",    err_count, 255);

        // Reset in the middle of a filter window
        seg_in = 7'h06;
        repeat (2) @(negedge clk);
        do_reset();
        wait_dv(lat);
        check("reset_latency", lat, S + 2);
        check("reset_digit1",  digit, 1);
        check("reset_err0",    err_count, 0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_digit_receiver.md
SEG7_DIGIT_RECEIVER -- requirements
Module: seg7_digit_receiver

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples required to accept a pattern (legal 2..15).
REQ-002 SHALL have parameter PERIOD_W, default 24: width of the period measurement.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 seg_in  input  7  segment bus {g,f,e,d,c,b,a}, active-high, asynchronous to clk.
REQ-006 digit  output  4  last accepted valid digit, 0..9.
REQ-007 digit_valid  output  1  one-cycle pulse when digit updates.
REQ-008 pattern_err  output  1  one-cycle pulse when a non-digit, non-blank pattern is accepted.
REQ-009 seq_err  output  1  one-cycle pulse when an accepted digit is not (previous+1) mod 10.
REQ-010 err_count  output  8  saturating count of pattern_err plus seq_err events.
REQ-011 period  output  PERIOD_W  clk cycles between the last two digit_valid pulses.
REQ-012 period_valid  output  1  one-cycle pulse, coincident with digit_valid, when period updates.

Function
REQ-013 seg_in SHALL pass through a 2-flop synchronizer; only the second flop feeds downstream logic.
REQ-014 A candidate pattern SHALL be accepted after STABLE_CYCLES consecutive equal synchronized samples; any change restarts the stability count.
REQ-015 A pattern equal to the last accepted pattern SHALL NOT be re-accepted; it produces no pulse.
REQ-016 Decode: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9; 0x00 = blank; all others invalid.
REQ-017 Latency: new seg_in held stable is reflected on digit/digit_valid exactly STABLE_CYCLES+2 rising edges after the first edge sampling it.
REQ-018 FSM states UNLOCKED (no reference digit) and LOCKED; reset enters UNLOCKED.
REQ-019 UNLOCKED, valid digit accepted: update digit, pulse digit_valid, no seq check, clear period counter, go LOCKED.
REQ-020 LOCKED, valid digit accepted: update digit, pulse digit_valid; pulse seq_err if not (previous+1) mod 10 (9->0 is legal); capture period; pulse period_valid; clear period counter.
REQ-021 Invalid pattern accepted in either state: pulse pattern_err; digit, state and period counter unchanged.
REQ-022 Blank accepted: no pulses, no error; go UNLOCKED.
REQ-023 Period counter SHALL increment every cycle in LOCKED and saturate at all-ones; pulses at edges t1 and t2 yield period = t2-t1.
REQ-024 err_count SHALL saturate at 255; pattern_err and seq_err are mutually exclusive, so it increments by at most 1 per cycle.

Reset
REQ-025 On reset: digit=0, digit_valid=0, pattern_err=0, seq_err=0, err_count=0, period=0, period_valid=0, FSM=UNLOCKED.
REQ-026 On reset: synchronizer flops, stability counter, candidate and last-accepted pattern registers cleared to 0, so 0x00 counts as already accepted.
REQ-027 Reset asserted mid-filter SHALL discard the partial stability count; no pulse may follow reset release without a fresh STABLE_CYCLES window.

Structure
REQ-028 Segment encoding constants (ten digit codes, blank code) and digit width SHALL live in shared package seg7_pkg.
REQ-029 Combinational pattern-to-{digit,valid,blank} decoding SHALL be sub-module seg7_decode; filter, FSM, counters stay in seg7_digit_receiver.

Verification
REQ-030 Drive 0x3F,0x06,...,0x6F,0x3F, each held 1000 cycles -> 11 digit_valid pulses, digits 0..9,0, seq_err never, period=1000 on pulses 2..11.
REQ-031 From LOCKED with digit 3, apply 0x66 for 3 cycles then back to 0x4F, STABLE_CYCLES=4 -> no pulses, digit stays 3.
REQ-032 Digit 2 then 0x7D -> digit_valid, digit=6, seq_err pulse, err_count=1; then 0x49 -> pattern_err, digit stays 6, err_count=2.
REQ-033 Digit 5, blank 0x00, then 0x06 -> no error on blank; digit=1 with no seq_err and no period_valid.
REQ-034 300 alternating invalid patterns 0x01/0x02, each held 10 cycles -> err_count saturates at 255.
REQ-035 Assert reset 2 cycles after 0x06 enters synchronizer, release, hold 0x06 -> digit_valid exactly STABLE_CYCLES+2 edges after release, digit=1.
